// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer
//   Drains the upstream sample FIFO (sole reader) and emits byte-oriented
//   frames on a valid/ready stream:
//     SYNC0 SYNC1 SEQ LEN payload[LEN*BPW bytes, MSB first] CSUM
//   CSUM is the XOR of SEQ, LEN and every payload byte.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   enable            allows new frames to start (checked only in IDLE)
//   flush             one-cycle request to send a short frame from residual words
//   fifo_rd_en        one-cycle read strobe per word
//   fifo_rd_data      read data, valid the cycle after fifo_rd_en
//   fifo_empty        FIFO empty flag
//   fifo_count        FIFO occupancy
//   tx_data/tx_valid  output byte stream, transfer on tx_valid && tx_ready
//   tx_ready          downstream accept
//   busy              high whenever the packer is not IDLE
//   frame_done        one-cycle pulse after the checksum byte is accepted
//   seq_num           sequence number of the next frame to be sent
module fifo_frame_packer #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned WORDS_PER_FRAME = 8,
    parameter int unsigned CNT_WIDTH       = 11,
    parameter logic [7:0]  SYNC0           = 8'hA5,
    parameter logic [7:0]  SYNC1           = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_count,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            seq_num
);

    localparam int unsigned BPW    = DATA_WIDTH / 8;
    localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [BIDX_W-1:0]    LAST_BYTE = BIDX_W'(BPW - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_WPF   = CNT_WIDTH'(WORDS_PER_FRAME);
    localparam logic [7:0]           LEN_WPF   = 8'(WORDS_PER_FRAME);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_SEQ,
        S_LEN,
        S_FETCH,
        S_LATCH,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    // Registers
    state_t                r_state;
    logic [7:0]            r_len;
    logic [7:0]            r_words_sent;
    logic [BIDX_W-1:0]     r_byte_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic [7:0]            r_csum;
    logic [7:0]            r_seq;
    logic                  r_flush_pending;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_data;
    logic                  r_fifo_rd_en;
    logic                  r_busy;
    logic                  r_frame_done;

    // Next-state values
    state_t                w_state_nxt;
    logic [7:0]            w_len_nxt;
    logic [7:0]            w_words_sent_nxt;
    logic [BIDX_W-1:0]     w_byte_idx_nxt;
    logic [DATA_WIDTH-1:0] w_word_nxt;
    logic [7:0]            w_csum_nxt;
    logic [7:0]            w_seq_nxt;
    logic                  w_flush_pending_nxt;
    logic                  w_tx_valid_nxt;
    logic [7:0]            w_tx_data_nxt;
    logic                  w_fifo_rd_en_nxt;
    logic                  w_busy_nxt;
    logic                  w_frame_done_nxt;
    logic [31:0]           w_shift;

    // Handshake and start decode
    logic w_xfer;
    logic w_start_norm;
    logic w_start_flush;
    logic w_start;
    logic w_last_byte;
    logic w_more_words;

    assign w_xfer        = r_tx_valid && tx_ready;
    assign w_start_norm  = enable && (fifo_count >= CNT_WPF);
    assign w_start_flush = enable && r_flush_pending && (fifo_count != '0);
    assign w_start       = w_start_norm || w_start_flush;
    assign w_last_byte   = (r_byte_idx == LAST_BYTE);
    assign w_more_words  = (r_words_sent < r_len);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_state_nxt = S_HDR0;
            S_HDR0:    if (w_xfer)  w_state_nxt = S_HDR1;
            S_HDR1:    if (w_xfer)  w_state_nxt = S_SEQ;
            S_SEQ:     if (w_xfer)  w_state_nxt = S_LEN;
            S_LEN:     if (w_xfer)  w_state_nxt = S_FETCH;
            // Leave FETCH only once the read strobe has actually been issued
            S_FETCH:   if (r_fifo_rd_en) w_state_nxt = S_LATCH;
            S_LATCH:   w_state_nxt = S_PAYLOAD;
            S_PAYLOAD: begin
                if (w_xfer && w_last_byte) begin
                    w_state_nxt = w_more_words ? S_FETCH : S_CSUM;
                end
            end
            S_CSUM:    if (w_xfer)  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values; outputs are computed from the next
    // state so that every output leaves a flop.
    always_comb begin
        w_len_nxt           = r_len;
        w_words_sent_nxt    = r_words_sent;
        w_byte_idx_nxt      = r_byte_idx;
        w_word_nxt          = r_word;
        w_csum_nxt          = r_csum;
        w_seq_nxt           = r_seq;
        w_flush_pending_nxt = r_flush_pending;
        w_frame_done_nxt    = 1'b0;
        w_tx_data_nxt       = 8'h00;
        w_shift             = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    // Flush length is below WORDS_PER_FRAME, so it fits in 8 bits
                    w_len_nxt           = w_start_norm ? LEN_WPF : 8'(fifo_count);
                    w_words_sent_nxt    = 8'd0;
                    w_byte_idx_nxt      = '0;
                    w_csum_nxt          = 8'h00;
                    w_flush_pending_nxt = 1'b0;
                end else if (fifo_count == '0) begin
                    w_flush_pending_nxt = 1'b0;
                end
            end
            S_SEQ, S_LEN: begin
                if (w_xfer) w_csum_nxt = r_csum ^ r_tx_data;
            end
            S_FETCH: begin
                if (r_fifo_rd_en) w_words_sent_nxt = r_words_sent + 8'd1;
            end
            S_LATCH: begin
                w_word_nxt = fifo_rd_data;
            end
            S_PAYLOAD: begin
                if (w_xfer) begin
                    w_csum_nxt     = r_csum ^ r_tx_data;
                    w_byte_idx_nxt = w_last_byte ? '0 : r_byte_idx + BIDX_W'(1);
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_frame_done_nxt = 1'b1;
                    w_seq_nxt        = r_seq + 8'd1;
                end
            end
            default: ;
        endcase

        // A flush request is always recorded, even in the cycle a frame starts
        if (flush) w_flush_pending_nxt = 1'b1;

        // MSB-first byte select of the (possibly just latched) word
        w_shift = 32'(LAST_BYTE - w_byte_idx_nxt) << 3;

        case (w_state_nxt)
            S_HDR0:    w_tx_data_nxt = SYNC0;
            S_HDR1:    w_tx_data_nxt = SYNC1;
            S_SEQ:     w_tx_data_nxt = w_seq_nxt;
            S_LEN:     w_tx_data_nxt = w_len_nxt;
            S_PAYLOAD: w_tx_data_nxt = 8'(w_word_nxt >> w_shift);
            S_CSUM:    w_tx_data_nxt = w_csum_nxt;
            default:   w_tx_data_nxt = 8'h00;
        endcase

        w_tx_valid_nxt = (w_state_nxt == S_HDR0) || (w_state_nxt == S_HDR1) ||
                         (w_state_nxt == S_SEQ)  || (w_state_nxt == S_LEN)  ||
                         (w_state_nxt == S_PAYLOAD) || (w_state_nxt == S_CSUM);

        // Registered strobe: only issued when the FIFO reports data
        w_fifo_rd_en_nxt = (w_state_nxt == S_FETCH) && !fifo_empty && !r_fifo_rd_en;

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len           <= 8'd0;
            r_words_sent    <= 8'd0;
            r_byte_idx      <= '0;
            r_word          <= '0;
            r_csum          <= 8'h00;
            r_seq           <= 8'h00;
            r_flush_pending <= 1'b0;
            r_tx_valid      <= 1'b0;
            r_tx_data       <= 8'h00;
            r_fifo_rd_en    <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_len           <= w_len_nxt;
            r_words_sent    <= w_words_sent_nxt;
            r_byte_idx      <= w_byte_idx_nxt;
            r_word          <= w_word_nxt;
            r_csum          <= w_csum_nxt;
            r_seq           <= w_seq_nxt;
            r_flush_pending <= w_flush_pending_nxt;
            r_tx_valid      <= w_tx_valid_nxt;
            r_tx_data       <= w_tx_data_nxt;
            r_fifo_rd_en    <= w_fifo_rd_en_nxt;
            r_busy          <= w_busy_nxt;
            r_frame_done    <= w_frame_done_nxt;
        end
    end

    assign fifo_rd_en = r_fifo_rd_en;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign seq_num    = r_seq;

endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb_fifo_frame_packer
//   Self-checking bench for fifo_frame_packer (WORDS_PER_FRAME=2, 32-bit words).
//   A queue stands in for the FIFO; expected frames are assembled from the
//   words pushed so far using the frame format rules.
`timescale 1ns/1ps
module tb_fifo_frame_packer;

    localparam int unsigned DW  = 32;
    localparam int unsigned WPF = 2;
    localparam int unsigned CW  = 11;
    localparam int unsigned BPW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          frame_done;
    logic [7:0]    seq_num;

    fifo_frame_packer #(
        .DATA_WIDTH      (DW),
        .WORDS_PER_FRAME (WPF),
        .CNT_WIDTH       (CW),
        .SYNC0           (8'hA5),
        .SYNC1           (8'h5A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flush        (flush),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .seq_num      (seq_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          mode;   // 0: ready always, 1: toggle 1,0,1,0, 2: random
        logic [7:0]  seq;
        logic [7:0]  csum;
    } vec_t;

    vec_t        vt[5];
    logic [31:0] fq[$];    // FIFO contents as seen by the DUT
    logic [31:0] ew[$];    // words not yet accounted for in an expected frame
    logic [7:0]  cap[$];   // bytes transferred in the current frame
    logic [7:0]  exp_f[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rd_cnt, fd_cnt, valid_cnt, rdy_mode;
    bit          tog, prev_stall, prev_fd;
    logic [7:0]  prev_data;
    logic [7:0]  exp_seq;
    logic [7:0]  last_seq_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic upd_cnt();
        fifo_count = CW'(fq.size());
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w);
        ew.push_back(w);
        upd_cnt();
    endtask

    function automatic logic [7:0] cap_at(input int i);
        if (i < cap.size()) return cap[i];
        return 8'hxx;
    endfunction

    // One clock: observe at the falling edge, serve the FIFO, pick tx_ready
    task automatic cyc();
        @(negedge clk);
        if (prev_stall) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (prev_fd) check("frame_done_width", 32'(frame_done), 32'd0);
        if (frame_done) fd_cnt++;
        if (tx_valid) begin
            valid_cnt++;
            check("busy_with_valid", 32'(busy), 32'd1);
        end
        if (fifo_rd_en) begin
            rd_cnt++;
            check("rd_while_empty", 32'(fifo_empty), 32'd0);
            if (fq.size() > 0) fifo_rd_data = fq.pop_front();
            upd_cnt();
        end
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       begin tog = ~tog; tx_ready = tog; end
            default: tx_ready = ($urandom_range(3) != 0);
        endcase
        if (tx_valid && tx_ready) cap.push_back(tx_data);
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_fd    = frame_done;
    endtask

    // Run until frame_done; optionally drop enable once drop_at bytes are seen
    task automatic run_frame(input string name, input int budget, input int drop_at);
        int n;
        n = 0;
        cap.delete();
        rd_cnt = 0;
        fd_cnt = 0;
        while (fd_cnt == 0 && n < budget) begin
            cyc();
            n++;
            if (drop_at >= 0 && cap.size() == drop_at) enable = 1'b0;
        end
        if (fd_cnt == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no frame_done within %0d cycles (bytes seen %0d)", name, budget, cap.size());
        end
    endtask

    // Reference frame from the next n model words
    task automatic expect_frame(input int n);
        logic [7:0]  x;
        logic [31:0] w;
        exp_f.delete();
        exp_f.push_back(8'hA5);
        exp_f.push_back(8'h5A);
        exp_f.push_back(exp_seq);
        exp_f.push_back(8'(n));
        x = exp_seq ^ 8'(n);
        for (int i = 0; i < n; i++) begin
            w = (ew.size() > 0) ? ew.pop_front() : 32'h0;
            for (int b = BPW - 1; b >= 0; b--) begin
                exp_f.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        exp_f.push_back(x);
    endtask

    task automatic compare_frame(input string name, input int nwords);
        int bad;
        bad = -1;
        expect_frame(nwords);
        n_tests++;
        for (int i = 0; i < exp_f.size(); i++) begin
            if (bad < 0 && cap_at(i) !== exp_f[i]) bad = i;
        end
        if (cap.size() != exp_f.size() && bad < 0) bad = exp_f.size();
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: %0d bytes got, %0d expected; first diff at byte %0d got %02h expected %02h",
                     name, cap.size(), exp_f.size(), bad, cap_at(bad),
                     (bad < exp_f.size()) ? exp_f[bad] : 8'hxx);
        end
        check({name, "_rd_count"}, 32'(rd_cnt), 32'(nwords));
        exp_seq = exp_seq + 8'd1;
        check({name, "_seq_num"}, 32'(seq_num), 32'(exp_seq));
    endtask

    task automatic idle_cycles(input int n);
        valid_cnt = 0;
        rd_cnt    = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h11223344, 32'h55667788, 0, 8'h00, 8'h8A};
        vt[1] = '{32'h11223344, 32'h55667788, 1, 8'h01, 8'h8B};
        vt[2] = '{32'h00000000, 32'h00000000, 2, 8'h02, 8'h00};
        vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 8'h03, 8'h01};
        vt[4] = '{32'hDEADBEEF, 32'h01020304, 1, 8'h04, 8'h20};

        rst = 1'b1; enable = 1'b0; flush = 1'b0; tx_ready = 1'b0;
        fifo_rd_data = '0; rdy_mode = 0; tog = 1'b0;
        prev_stall = 1'b0; prev_fd = 1'b0; prev_data = 8'h00; exp_seq = 8'h00;
        upd_cnt();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_valid",   32'(tx_valid),   32'd0);
        check("rst_tx_data",    32'(tx_data),    32'd0);
        check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_seq_num",    32'(seq_num),    32'd0);
        rst = 1'b0;
        enable = 1'b1;

        // Table-driven frames: basic, backpressure, patterns
        for (int i = 0; i < 5; i++) begin
            rdy_mode = vt[i].mode;
            push_word(vt[i].w0);
            push_word(vt[i].w1);
            run_frame("vec_frame", 400, -1);
            check("vec_seq_byte", 32'(cap_at(2)), 32'(vt[i].seq));
            check("vec_csum", 32'(cap_at(12)), 32'(vt[i].csum));
            compare_frame("vec_model", 2);
        end

        // Below threshold: nothing happens until flush
        rdy_mode = 0;
        push_word(32'hCAFEF00D);
        idle_cycles(20);
        check("thresh_no_valid", 32'(valid_cnt), 32'd0);
        check("thresh_no_rd", 32'(rd_cnt), 32'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        run_frame("flush_frame", 400, -1);
        check("flush_len", 32'(cap_at(3)), 32'd1);
        compare_frame("flush_model", 1);
        // flush_pending must be gone: one lone word must not start a frame
        push_word(32'h0BADBEEF);
        idle_cycles(20);
        check("post_flush_no_valid", 32'(valid_cnt), 32'd0);
        check("post_flush_no_rd", 32'(rd_cnt), 32'd0);
        push_word(32'h13579BDF);
        run_frame("resid_frame", 400, -1);
        compare_frame("resid_model", 2);

        // Async reset in PAYLOAD right after byte 0x22 is accepted
        push_word(32'h11223344);
        push_word(32'h55667788);
        cap.delete();
        for (int i = 0; i < 100 && cap.size() < 6; i++) cyc();
        check("pre_reset_bytes", 32'(cap.size()), 32'd6);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'd0);
        check("async_rd_en", 32'(fifo_rd_en), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_seq_num", 32'(seq_num), 32'd0);
        fq.delete(); ew.delete(); upd_cnt();
        exp_seq = 8'h00; prev_stall = 1'b0; prev_fd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push_word(32'h11223344);
        push_word(32'h55667788);
        run_frame("post_reset_frame", 400, -1);
        compare_frame("post_reset_model", 2);

        // Enable dropped while LEN is on the bus with two frames queued
        for (int i = 0; i < 2 * WPF; i++) push_word($urandom);
        run_frame("en_drop_frame", 400, 4);
        compare_frame("en_drop_model", 2);
        idle_cycles(30);
        check("en_off_no_valid", 32'(valid_cnt), 32'd0);
        check("en_off_no_rd", 32'(rd_cnt), 32'd0);
        enable = 1'b1;
        run_frame("en_on_frame", 400, -1);
        check("en_on_seq_byte", 32'(cap_at(2)), 32'(exp_seq));
        compare_frame("en_on_model", 2);

        // 257 back-to-back frames with random backpressure: SEQ wraps
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_seq = 8'h00; prev_stall = 1'b0; prev_fd = 1'b0;
        rdy_mode = 2;
        for (int i = 0; i < 257 * WPF; i++) push_word($urandom);
        for (int f = 0; f < 257; f++) begin
            run_frame("wrap_frame", 400, -1);
            last_seq_byte = cap_at(2);
            compare_frame("wrap_model", 2);
        end
        check("wrap_last_seq_byte", 32'(last_seq_byte), 32'h00);
        check("wrap_seq_num", 32'(seq_num), 32'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
- Drains the sample FIFO (`fifo_sync`) directly downstream of it.
- Packs stored words into byte-oriented frames: sync header, sequence number, length, payload and XOR checksum.
- Presents frames on a valid/ready byte stream to the UART/BLE transmit stage.
- Is the only reader of the FIFO.

Parameters:
- DATA_WIDTH, 32, FIFO word width; must be a multiple of 8. BPW = DATA_WIDTH/8 bytes per word.
- WORDS_PER_FRAME, 8, nominal payload words per frame; range 1..255.
- CNT_WIDTH, 11, width of the FIFO count input (ADDR_WIDTH+1 for a 1024-deep FIFO).
- SYNC0, 8'hA5, first header byte.
- SYNC1, 8'h5A, second header byte.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  allows new frames to start
- flush  in  1  single-cycle request to send a short frame from residual words
- fifo_rd_en  out  1  FIFO read strobe, one-cycle pulse per word
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_count  in  CNT_WIDTH  FIFO occupancy
- tx_data  out  8  output byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts the byte
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse when the checksum byte is accepted
- seq_num  out  8  sequence number of the next frame to be sent

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; tx_valid=0, tx_data=0, fifo_rd_en=0, busy=0, frame_done=0, seq_num=0.
  - flush_pending=0; word register and checksum cleared.
  - Words already popped when reset hits mid-frame are discarded; no resume.
- All outputs are registered.
- Byte transfer occurs on a cycle with tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid are held stable.
  - tx_valid never drops without a transfer, except on reset.
- flush pulse sets flush_pending.
  - flush_pending clears when a frame starts.
  - flush_pending also clears in IDLE when fifo_count==0.
- Frame start, evaluated only in IDLE:
  - Normal start: enable && fifo_count>=WORDS_PER_FRAME gives len=WORDS_PER_FRAME.
  - Flush start: else enable && flush_pending && fifo_count>0 gives len=fifo_count, which is necessarily <WORDS_PER_FRAME.
  - len is latched at start and unaffected by later count changes.
  - Start condition true at edge N means tx_valid=1 with tx_data=SYNC0 after edge N.
- States:
  - IDLE: waits for a start condition; then goes to HDR0.
  - HDR0: sends SYNC0; on transfer goes to HDR1.
  - HDR1: sends SYNC1; on transfer goes to SEQ.
  - SEQ: sends seq_num; on transfer goes to LEN.
  - LEN: sends len (8 bits); on transfer goes to FETCH.
  - FETCH: tx_valid=0, fifo_rd_en=1 for exactly one cycle; then goes to LATCH.
  - LATCH: captures fifo_rd_data into the word register; next cycle enters PAYLOAD.
  - PAYLOAD:
    - Sends BPW bytes MSB first; each byte is held until transferred.
    - After the last byte transfer: if words_sent<len, go to FETCH; else go to CSUM.
  - CSUM: sends the checksum. On transfer:
    - frame_done pulses for one cycle.
    - seq_num increments modulo 256 (255 wraps to 0).
    - State returns to IDLE.
- Checksum: 8-bit XOR of the SEQ byte, the LEN byte and all payload bytes. SYNC bytes are excluded.
- Timing: each payload word costs 2 bubble cycles (FETCH, LATCH) plus BPW transfer cycles; no fetch overlap.
- FIFO interaction:
  - fifo_rd_en is never asserted while fifo_empty=1.
  - Exactly len reads occur per frame.
- enable deasserted mid-frame: the current frame completes fully; no new frame starts.
- flush while busy: recorded, and evaluated once the state returns to IDLE.
- IDLE with enable=1 and fifo_count>=WORDS_PER_FRAME after CSUM: the next frame starts on the following cycle.

Test Plan:
- Basic frame (WORDS_PER_FRAME=2). FIFO holds 32'h11223344 then 32'h55667788; enable=1, tx_ready=1.
  - Bytes are A5 5A 00 02 11 22 33 44 55 66 77 88 8A.
  - frame_done pulses once; seq_num goes 0 to 1; exactly 2 fifo_rd_en pulses.
- Threshold and flush (WORDS_PER_FRAME=8). fifo_count=3 with enable=1 produces no fifo_rd_en and tx_valid stays 0.
  - A flush pulse then produces a frame with LEN=03 and 3 words.
  - flush_pending is clear afterwards; a second frame does not start.
- Backpressure. tx_ready toggles 1,0,1,0 through a frame.
  - tx_data stays stable whenever tx_valid=1 and tx_ready=0.
  - Byte sequence equals the basic case, with no duplicates or drops.
- Sequence wrap. Send 257 back-to-back frames.
  - SEQ bytes run 00..FF then 00; each checksum matches the XOR model.
- Async reset mid-PAYLOAD (after byte 0x22).
  - tx_valid, fifo_rd_en and busy drop immediately; seq_num=0.
  - After release with 2 words in the FIFO, the next frame starts with A5 5A 00 02.
- Enable drop mid-frame. Deassert enable during LEN while fifo_count>=2*WORDS_PER_FRAME.
  - The current frame completes with CSUM; no further HDR0 while enable=0.
  - Re-asserting enable starts the next frame with seq 01.
